ha_accumulator: RTL and testbench

HA_ACCUMULATOR -- requirements
Module: ha_accumulator

---
 rtl/ha_accumulator.sv | 127 ++++++++++++
 tb/tb_ha_accumulator.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ha_accumulator.sv
// ha_accumulator: accumulates half-adder samples (2*carry + sum) into a
// saturating total over a window of COUNT_MAX samples, then holds the result
// until the downstream consumer takes it.
module ha_accumulator #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned COUNT_MAX = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sum,
    input  logic             in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_total,
    output logic [7:0]       out_count,
    output logic             out_sat,
    output logic             out_err
);

    localparam int unsigned CW = 8;
    // Two guard bits so that max total + 3 never wraps, even for WIDTH=1.
    localparam int unsigned EW = WIDTH + 2;

    localparam logic [EW-1:0] TOTAL_MAX = {2'b00, {WIDTH{1'b1}}};
    localparam logic [CW-1:0] LAST_CNT  = CW'(COUNT_MAX);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [WIDTH-1:0] total_q, total_d;
    logic [CW-1:0]    count_q, count_d;
    logic             sat_q,   sat_d;
    logic             err_q,   err_d;
    logic             valid_q, valid_d;

    logic [1:0]       sample;
    logic [EW-1:0]    sum_ext;
    logic [CW-1:0]    count_inc;

    assign sample    = {in_carry, in_sum};
    assign sum_ext   = EW'(total_q) + EW'(sample);
    assign count_inc = count_q + CW'(1);

    // Next-state and datapath update; clear outranks accept and out_ready.
    always_comb begin
        state_d = state_q;
        total_d = total_q;
        count_d = count_q;
        sat_d   = sat_q;
        err_d   = err_q;
        valid_d = valid_q;

        if (clear) begin
            state_d = ACCUM;
            total_d = '0;
            count_d = '0;
            sat_d   = 1'b0;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (in_valid) begin
                        if (sum_ext > TOTAL_MAX) begin
                            total_d = {WIDTH{1'b1}};
                            sat_d   = 1'b1;
                        end else begin
                            total_d = WIDTH'(sum_ext);
                        end
                        count_d = count_inc;
                        if (sample == 2'b11) begin
                            err_d = 1'b1;
                        end
                        if (count_inc == LAST_CNT) begin
                            state_d = HOLD;
                            valid_d = 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_d = ACCUM;
                        total_d = '0;
                        count_d = '0;
                        sat_d   = 1'b0;
                        valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d = ACCUM;
                end
            endcase
        end
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACCUM;
            total_q <= '0;
            count_q <= '0;
            sat_q   <= 1'b0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            total_q <= total_d;
            count_q <= count_d;
            sat_q   <= sat_d;
            err_q   <= err_d;
            valid_q <= valid_d;
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = valid_q;
    assign out_total = total_q;
    assign out_count = count_q;
    assign out_sat   = sat_q;
    assign out_err   = err_q;

endmodule

// File: tb/tb_ha_accumulator.sv
// Bench for ha_accumulator: a WIDTH=8 and a WIDTH=4 instance share stimulus
// and are compared every cycle against an integer window model.
module tb_ha_accumulator;

    localparam int unsigned CMAX = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, clear, in_valid, in_sum, in_carry, out_ready;

    logic       a_in_ready, a_out_valid, a_out_sat, a_out_err;
    logic [7:0] a_out_total, a_out_count;
    logic       b_in_ready, b_out_valid, b_out_sat, b_out_err;
    logic [3:0] b_out_total;
    logic [7:0] b_out_count;

    ha_accumulator #(.WIDTH(8), .COUNT_MAX(CMAX)) u_a (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid),
        .in_ready(a_in_ready), .in_sum(in_sum), .in_carry(in_carry),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .out_total(a_out_total), .out_count(a_out_count),
        .out_sat(a_out_sat), .out_err(a_out_err)
    );

    ha_accumulator #(.WIDTH(4), .COUNT_MAX(CMAX)) u_b (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid),
        .in_ready(b_in_ready), .in_sum(in_sum), .in_carry(in_carry),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .out_total(b_out_total), .out_count(b_out_count),
        .out_sat(b_out_sat), .out_err(b_out_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: index 0 = WIDTH 8, index 1 = WIDTH 4.
    int m_limit [2] = '{255, 15};
    int m_total [2];
    int m_count [2];
    bit m_sat   [2];
    bit m_err   [2];
    bit m_full  [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_total[i] = 0; m_count[i] = 0; m_sat[i] = 0; m_err[i] = 0; m_full[i] = 0;
            end else if (clear) begin
                m_total[i] = 0; m_count[i] = 0; m_sat[i] = 0; m_full[i] = 0;
            end else if (m_full[i]) begin
                if (out_ready) begin
                    m_total[i] = 0; m_count[i] = 0; m_sat[i] = 0; m_full[i] = 0;
                end
            end else if (in_valid) begin
                int v;
                int raw;
                v   = 2 * int'(in_carry) + int'(in_sum);
                raw = m_total[i] + v;
                if (v == 3) m_err[i] = 1;
                if (raw > m_limit[i]) m_sat[i] = 1;
                m_total[i] = (raw > m_limit[i]) ? m_limit[i] : raw;
                m_count[i] = m_count[i] + 1;
                if (m_count[i] == int'(CMAX)) m_full[i] = 1;
            end
        end
    endtask

    // One clock: update model from present inputs, then check both DUTs.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        chk("a.in_ready",  32'(a_in_ready),  32'(!m_full[0]));
        chk("a.out_valid", 32'(a_out_valid), 32'(m_full[0]));
        chk("a.out_count", 32'(a_out_count), 32'(m_count[0]));
        chk("a.out_sat",   32'(a_out_sat),   32'(m_sat[0]));
        chk("a.out_err",   32'(a_out_err),   32'(m_err[0]));
        chk("a.out_total", 32'(a_out_total), 32'(m_total[0]));
        chk("b.in_ready",  32'(b_in_ready),  32'(!m_full[1]));
        chk("b.out_valid", 32'(b_out_valid), 32'(m_full[1]));
        chk("b.out_count", 32'(b_out_count), 32'(m_count[1]));
        chk("b.out_sat",   32'(b_out_sat),   32'(m_sat[1]));
        chk("b.out_err",   32'(b_out_err),   32'(m_err[1]));
        chk("b.out_total", 32'(b_out_total), 32'(m_total[1]));
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_sum = 1'b0; in_carry = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_total[i] = 0; m_count[i] = 0; m_sat[i] = 0; m_err[i] = 0; m_full[i] = 0;
        end
        step(); step();
        chk("reset.total", 32'(a_out_total), 32'd0);
        chk("reset.valid", 32'(a_out_valid), 32'd0);

        // First cycle out of reset is ready.
        rst = 1'b0;
        step();
        chk("post_reset.in_ready", 32'(a_in_ready), 32'd1);

        // 16 samples of value 1.
        in_valid = 1'b1; in_sum = 1'b1; in_carry = 1'b0;
        for (int k = 0; k < 15; k++) step();
        chk("win1.valid_before_last", 32'(a_out_valid), 32'd0);
        step();
        chk("win1.out_valid", 32'(a_out_valid), 32'd1);
        chk("win1.out_total", 32'(a_out_total), 32'd16);
        chk("win1.out_count", 32'(a_out_count), 32'd16);
        chk("win1.out_sat",   32'(a_out_sat),   32'd0);
        chk("win1.in_ready",  32'(a_in_ready),  32'd0);
        chk("win1.b_total",   32'(b_out_total), 32'd15);
        chk("win1.b_sat",     32'(b_out_sat),   32'd1);

        // Hold with in_valid high for 5 cycles, then release.
        for (int k = 0; k < 5; k++) step();
        chk("hold.out_total", 32'(a_out_total), 32'd16);
        chk("hold.out_count", 32'(a_out_count), 32'd16);
        out_ready = 1'b1; in_valid = 1'b0;
        step();
        out_ready = 1'b0;
        chk("release.in_ready",  32'(a_in_ready),  32'd1);
        chk("release.out_total", 32'(a_out_total), 32'd0);
        chk("release.out_count", 32'(a_out_count), 32'd0);

        // 16 samples of value 2: WIDTH 4 clamps at 15.
        in_valid = 1'b1; in_sum = 1'b0; in_carry = 1'b1;
        for (int k = 0; k < 16; k++) step();
        chk("sat.b_total", 32'(b_out_total), 32'd15);
        chk("sat.b_sat",   32'(b_out_sat),   32'd1);
        chk("sat.a_total", 32'(a_out_total), 32'd32);
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Clear after 7 accepts, with a sample offered alongside.
        in_valid = 1'b1; in_sum = 1'b1; in_carry = 1'b0;
        for (int k = 0; k < 7; k++) step();
        chk("pre_clear.count", 32'(a_out_count), 32'd7);
        clear = 1'b1;
        step();
        clear = 1'b0; in_valid = 1'b0;
        chk("clear.count", 32'(a_out_count), 32'd0);
        chk("clear.total", 32'(a_out_total), 32'd0);

        // Illegal sample sets sticky err through completion and clear.
        in_valid = 1'b1; in_sum = 1'b1; in_carry = 1'b1;
        step();
        chk("err.set", 32'(a_out_err), 32'd1);
        in_sum = 1'b0; in_carry = 1'b0;
        for (int k = 0; k < 15; k++) step();
        chk("err.hold_valid", 32'(a_out_valid), 32'd1);
        chk("err.hold_total", 32'(a_out_total), 32'd3);
        chk("err.hold_err",   32'(a_out_err),   32'd1);
        in_valid = 1'b0; clear = 1'b1;
        step();
        clear = 1'b0;
        chk("err.after_clear", 32'(a_out_err), 32'd1);

        // Reset in HOLD together with out_ready.
        in_valid = 1'b1; in_sum = 1'b1;
        for (int k = 0; k < 16; k++) step();
        chk("rsthold.valid", 32'(a_out_valid), 32'd1);
        in_valid = 1'b0; rst = 1'b1; out_ready = 1'b1;
        step();
        rst = 1'b0; out_ready = 1'b0;
        chk("rsthold.in_ready", 32'(a_in_ready),  32'd1);
        chk("rsthold.total",    32'(a_out_total), 32'd0);
        chk("rsthold.err",      32'(a_out_err),   32'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("rsthold.no_valid", 32'(a_out_valid), 32'd0);
        end

        // Randomized traffic.
        for (int k = 0; k < 800; k++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_sum    = 1'($urandom_range(0, 1));
            in_carry  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 2) == 0);
            clear     = ($urandom_range(0, 39) == 0);
            rst       = ($urandom_range(0, 149) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
